// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU slice.
// ALUOp classes, R-type funct codes and ALU operation codes (gout).
package alu_pkg;

    localparam logic [1:0] ALUOP_LW_SW = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    localparam logic [2:0] GOUT_AND = 3'b000;
    localparam logic [2:0] GOUT_OR  = 3'b001;
    localparam logic [2:0] GOUT_ADD = 3'b010;
    localparam logic [2:0] GOUT_NOR = 3'b100;
    localparam logic [2:0] GOUT_SUB = 3'b110;
    localparam logic [2:0] GOUT_SLT = 3'b111;

endpackage

// File: rtl/alu_ctl_dec.sv
// ALU control decoder: ALUOp + funct -> 3-bit ALU operation code.
// Ports: aluop (2), funct (6) in; gout (3) out. Purely combinational.
module alu_ctl_dec
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] gout
);

    always_comb begin
        gout = GOUT_ADD;
        if (aluop[1]) begin
            // Unrecognised funct codes fall back to add.
            case (funct)
                FUNCT_ADD: gout = GOUT_ADD;
                FUNCT_SUB: gout = GOUT_SUB;
                FUNCT_AND: gout = GOUT_AND;
                FUNCT_OR:  gout = GOUT_OR;
                FUNCT_SLT: gout = GOUT_SLT;
                FUNCT_NOR: gout = GOUT_NOR;
                default:   gout = GOUT_ADD;
            endcase
        end else if (aluop[0]) begin
            gout = GOUT_SUB;
        end else begin
            gout = GOUT_ADD;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU control, 32-bit ALU with flags, PC+4 and branch adders.
// Ports: clk, rst, in_valid, aluop, funct, a, b, pc, offset in; registered
// out_valid, gout, result, zero, neg, ovf, pc_plus4, branch_target out.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] offset,
    output logic             out_valid,
    output logic [2:0]       gout,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target
);

    localparam int MSB = WIDTH - 1;

    logic [2:0]       gout_d;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf_add;
    logic             ovf_sub;
    logic             slt;
    logic [WIDTH-1:0] result_d;
    logic             ovf_d;
    logic [WIDTH-1:0] pc_plus4_d;
    logic [WIDTH-1:0] branch_target_d;

    logic             out_valid_q;
    logic [2:0]       gout_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
    logic [WIDTH-1:0] pc_plus4_q;
    logic [WIDTH-1:0] branch_target_q;

    alu_ctl_dec u_dec (
        .aluop (aluop),
        .funct (funct),
        .gout  (gout_d)
    );

    assign sum     = a + b;
    assign diff    = a - b;
    assign ovf_add = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    assign ovf_sub = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
    // Correcting the difference sign by overflow keeps slt exact
    // even when a - b wraps.
    assign slt     = diff[MSB] ^ ovf_sub;

    always_comb begin
        result_d = '0;
        ovf_d    = 1'b0;
        case (gout_d)
            GOUT_AND: result_d = a & b;
            GOUT_OR:  result_d = a | b;
            GOUT_ADD: begin
                result_d = sum;
                ovf_d    = ovf_add;
            end
            GOUT_SUB: begin
                result_d = diff;
                ovf_d    = ovf_sub;
            end
            GOUT_SLT: result_d = {{(WIDTH-1){1'b0}}, slt};
            GOUT_NOR: result_d = ~(a | b);
            default:  result_d = '0;
        endcase
    end

    assign pc_plus4_d      = pc + WIDTH'(4);
    assign branch_target_d = pc_plus4_d + offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            gout_q          <= '0;
            result_q        <= '0;
            zero_q          <= 1'b1;
            neg_q           <= 1'b0;
            ovf_q           <= 1'b0;
            pc_plus4_q      <= '0;
            branch_target_q <= '0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                gout_q          <= gout_d;
                result_q        <= result_d;
                zero_q          <= (result_d == '0);
                neg_q           <= result_d[MSB];
                ovf_q           <= ovf_d;
                pc_plus4_q      <= pc_plus4_d;
                branch_target_q <= branch_target_d;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign gout          = gout_q;
    assign result        = result_q;
    assign zero          = zero_q;
    assign neg           = neg_q;
    assign ovf           = ovf_q;
    assign pc_plus4      = pc_plus4_q;
    assign branch_target = branch_target_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage.
// Each task drives one scenario and checks the registered outputs.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a, b, pc, offset;
    logic        out_valid;
    logic [2:0]  gout;
    logic [31:0] result;
    logic        zero, neg, ovf;
    logic [31:0] pc_plus4, branch_target;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .aluop         (aluop),
        .funct         (funct),
        .a             (a),
        .b             (b),
        .pc            (pc),
        .offset        (offset),
        .out_valid     (out_valid),
        .gout          (gout),
        .result        (result),
        .zero          (zero),
        .neg           (neg),
        .ovf           (ovf),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target)
    );

    // Drive one cycle of inputs, clock it in, and settle past the edge.
    task automatic apply(input logic v, input logic [1:0] op,
                         input logic [5:0] fn, input logic [31:0] ia,
                         input logic [31:0] ib);
        in_valid = v;
        aluop    = op;
        funct    = fn;
        a        = ia;
        b        = ib;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; aluop = 2'b00; funct = 6'd0;
        a = 32'd0; b = 32'd0; pc = 32'd0; offset = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({out_valid, gout, result, zero, neg, ovf, pc_plus4, branch_target}
            !== {1'b0, 3'b000, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL reset_state: v=%b g=%b r=%h z=%b n=%b o=%b p4=%h bt=%h want all 0, zero=1",
                     out_valid, gout, result, zero, neg, ovf, pc_plus4, branch_target);
        end
        apply(1'b1, 2'b00, 6'd0, 32'd5, 32'd3);
        checks++;
        if ({out_valid, result, gout} !== {1'b1, 32'd8, 3'b010}) begin
            failures++;
            $display("FAIL first_lw: v=%b r=%h g=%b want v=1 r=00000008 g=010",
                     out_valid, result, gout);
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [6] = '{6'b100000, 6'b100010, 6'b100100,
                               6'b100101, 6'b100111, 6'b101010};
        logic [31:0] er [6] = '{32'h16, 32'h2, 32'h8, 32'hE,
                               32'hFFFFFFF1, 32'h0};
        logic [2:0]  eg [6] = '{3'b010, 3'b110, 3'b000,
                               3'b001, 3'b100, 3'b111};
        logic        ez [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        en [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 2'b10, fn[i], 32'h0000000C, 32'h0000000A);
            checks++;
            if ({result, gout, zero, neg, ovf} !== {er[i], eg[i], ez[i], en[i], 1'b0}) begin
                failures++;
                $display("FAIL rtype_%0d: r=%h g=%b z=%b n=%b o=%b want r=%h g=%b z=%b n=%b o=0",
                         i, result, gout, zero, neg, ovf, er[i], eg[i], ez[i], en[i]);
            end
        end
        apply(1'b1, 2'b10, 6'b000000, 32'h0000000C, 32'h0000000A);
        checks++;
        if ({result, gout} !== {32'h16, 3'b010}) begin
            failures++;
            $display("FAIL rtype_unknown_funct: r=%h g=%b want r=00000016 g=010",
                     result, gout);
        end
    endtask

    task automatic test_overflow_slt();
        apply(1'b1, 2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1);
        checks++;
        if ({result, ovf, neg, zero} !== {32'h80000000, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL add_ovf: r=%h o=%b n=%b z=%b want r=80000000 o=1 n=1 z=0",
                     result, ovf, neg, zero);
        end
        apply(1'b1, 2'b10, 6'b101010, 32'h80000000, 32'h1);
        checks++;
        if ({result, ovf, gout} !== {32'h1, 1'b0, 3'b111}) begin
            failures++;
            $display("FAIL slt_ovf: r=%h o=%b g=%b want r=00000001 o=0 g=111",
                     result, ovf, gout);
        end
        apply(1'b1, 2'b10, 6'b100010, 32'h80000000, 32'h1);
        checks++;
        if ({result, ovf} !== {32'h7FFFFFFF, 1'b1}) begin
            failures++;
            $display("FAIL sub_ovf: r=%h o=%b want r=7fffffff o=1", result, ovf);
        end
    endtask

    task automatic test_branch();
        apply(1'b1, 2'b01, 6'b100101, 32'h1234, 32'h1234);
        checks++;
        if ({result, zero, gout} !== {32'h0, 1'b1, 3'b110}) begin
            failures++;
            $display("FAIL beq_equal: r=%h z=%b g=%b want r=0 z=1 g=110",
                     result, zero, gout);
        end
        apply(1'b1, 2'b01, 6'b100101, 32'h1235, 32'h1234);
        checks++;
        if ({result, zero} !== {32'h1, 1'b0}) begin
            failures++;
            $display("FAIL beq_differ: r=%h z=%b want r=00000001 z=0", result, zero);
        end
    endtask

    task automatic test_adders();
        pc = 32'h00000008; offset = 32'hFFFFFFF8;
        apply(1'b1, 2'b00, 6'd0, 32'd1, 32'd1);
        checks++;
        if ({pc_plus4, branch_target} !== {32'h0000000C, 32'h00000004}) begin
            failures++;
            $display("FAIL adders_neg_off: p4=%h bt=%h want p4=0000000c bt=00000004",
                     pc_plus4, branch_target);
        end
        pc = 32'hFFFFFFFC; offset = 32'h00000010;
        apply(1'b1, 2'b10, 6'b100100, 32'd1, 32'd1);
        checks++;
        if ({pc_plus4, branch_target} !== {32'h00000000, 32'h00000010}) begin
            failures++;
            $display("FAIL adders_wrap: p4=%h bt=%h want p4=00000000 bt=00000010",
                     pc_plus4, branch_target);
        end
    endtask

    task automatic test_hold_reset();
        pc = 32'h100; offset = 32'h20;
        apply(1'b1, 2'b10, 6'b100101, 32'hF0, 32'h0F);
        pc = 32'h500; offset = 32'h44;
        apply(1'b0, 2'b01, 6'b100010, 32'h3, 32'h3);
        checks++;
        if ({out_valid, result, gout, zero, pc_plus4, branch_target}
            !== {1'b0, 32'hFF, 3'b001, 1'b0, 32'h104, 32'h124}) begin
            failures++;
            $display("FAIL hold: v=%b r=%h g=%b z=%b p4=%h bt=%h want v=0 r=ff g=001 z=0 p4=104 bt=124",
                     out_valid, result, gout, zero, pc_plus4, branch_target);
        end
        rst = 1'b1;
        apply(1'b1, 2'b10, 6'b100111, 32'h1, 32'h2);
        rst = 1'b0;
        checks++;
        if ({out_valid, gout, result, zero, neg, ovf, pc_plus4, branch_target}
            !== {1'b0, 3'b000, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL reset_priority: v=%b g=%b r=%h z=%b n=%b o=%b p4=%h bt=%h want cleared, zero=1",
                     out_valid, gout, result, zero, neg, ovf, pc_plus4, branch_target);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_overflow_slt();
        test_branch();
        test_adders();
        test_hold_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
